// File: rtl/monopix_hit_pkg.sv
// Shared types, output word layout and Gray decode for the per-flavour hit formatter.
package monopix_hit_pkg;

    typedef struct packed {
        logic [5:0] col;
        logic [5:0] te;
        logic [5:0] le;
        logic [8:0] row;
    } t_data;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned COL_W        = 6;
    localparam int unsigned ROW_W        = 9;
    localparam int unsigned TS_W         = 6;
    localparam int unsigned MARKER_CNT_W = 16;

    localparam int unsigned HIT_FLAG_BIT = 31;
    localparam int unsigned COL_LSB      = 25;
    localparam int unsigned ROW_LSB      = 16;
    localparam int unsigned LE_LSB       = 10;
    localparam int unsigned TOT_LSB      = 4;

    localparam logic HIT_FLAG    = 1'b0;
    localparam logic MARKER_FLAG = 1'b1;

    function automatic logic [TS_W-1:0] gray_to_bin(input logic [TS_W-1:0] g);
        logic [TS_W-1:0] b;
        b[TS_W-1] = g[TS_W-1];
        for (int i = TS_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/hit_sync_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head word whenever empty is low.
module hit_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk_out,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count gates visibility of stale entries.
    always_ff @(posedge clk_out) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/hit_formatter.sv
// Two-stage hit decode/pack pipeline feeding an output FIFO, with drop counting and markers.
// Optional build macro TOT_CUT_EN discards hits whose ToT is below tot_min.
module hit_formatter
    import monopix_hit_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clk_out,
    input  logic                   reset,
    input  logic [26:0]            data_in,
    input  logic                   data_in_strobe,
    input  logic [5:0]             tot_min,
    output logic [31:0]            dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow
);

    t_data hit_in;
    assign hit_in = data_in;

    logic             s1_valid_q;
    logic [COL_W-1:0] s1_col_q;
    logic [ROW_W-1:0] s1_row_q;
    logic [TS_W-1:0]  s1_le_q;
    logic [TS_W-1:0]  s1_te_q;

    always_ff @(posedge clk_out) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_le_q    <= '0;
            s1_te_q    <= '0;
        end else begin
            s1_valid_q <= data_in_strobe;
            s1_col_q   <= hit_in.col;
            s1_row_q   <= hit_in.row;
            s1_le_q    <= gray_to_bin(hit_in.le);
            s1_te_q    <= gray_to_bin(hit_in.te);
        end
    end

    logic [TS_W-1:0]   s1_tot;
    logic [WORD_W-1:0] s1_word;

    always_comb begin
        s1_tot                      = s1_te_q - s1_le_q;
        s1_word                     = '0;
        s1_word[HIT_FLAG_BIT]       = HIT_FLAG;
        s1_word[COL_LSB +: COL_W]   = s1_col_q;
        s1_word[ROW_LSB +: ROW_W]   = s1_row_q;
        s1_word[LE_LSB +: TS_W]     = s1_le_q;
        s1_word[TOT_LSB +: TS_W]    = s1_tot;
    end

    logic              s2_valid_q;
    logic [WORD_W-1:0] s2_word_q;
    logic [TS_W-1:0]   s2_tot_q;

    always_ff @(posedge clk_out) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            s2_tot_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_word_q  <= s1_word;
            s2_tot_q   <= s1_tot;
        end
    end

    logic hit_ok;
`ifdef TOT_CUT_EN
    assign hit_ok = s2_valid_q && (s2_tot_q >= tot_min);
`else
    logic unused_tot;
    assign unused_tot = ^{tot_min, s2_tot_q};
    assign hit_ok     = s2_valid_q;
`endif

    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] marker_word;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        marker_word                        = '0;
        marker_word[HIT_FLAG_BIT]          = MARKER_FLAG;
        marker_word[MARKER_CNT_W-1:0]      = MARKER_CNT_W'(drop_cnt_q);
    end

    // fifo_full reflects occupancy before any same-cycle pop, so a pop never frees a slot early.
    always_comb begin
        wr_en      = 1'b0;
        wr_data    = s2_word_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (hit_ok) begin
            if (!fifo_full) begin
                wr_en = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {DROP_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end else if ((drop_cnt_q != '0) && !fifo_full) begin
            wr_en      = 1'b1;
            wr_data    = marker_word;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    hit_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_out (clk_out),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign dout_valid = !fifo_empty;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_hit_formatter.sv
// Directed bench for hit_formatter with a queue scoreboard of expected FIFO words.
module tb_hit_formatter;

    logic        clk_out;
    logic        reset;
    logic [26:0] data_in;
    logic        data_in_strobe;
    logic [5:0]  tot_min;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [4:0]  fifo_count;
    logic [15:0] drop_cnt;
    logic        overflow;

    hit_formatter #(
        .DEPTH  (16),
        .DROP_W (16)
    ) dut (
        .clk_out        (clk_out),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_strobe (data_in_strobe),
        .tot_min        (tot_min),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .fifo_count     (fifo_count),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] b2g(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] g2b(input logic [5:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4) ^ (g >> 5);
    endfunction

    function automatic logic [31:0] hit_word(input logic [5:0] col, input logic [8:0] row,
                                             input logic [5:0] le_b, input logic [5:0] te_b);
        logic [5:0] tot;
        tot = te_b - le_b;
        return {1'b0, col, row, le_b, tot, 4'b0000};
    endfunction

    // Drive one strobe at the current negedge; returns at the next negedge.
    task automatic send_hit(input logic [5:0] col, input logic [8:0] row,
                            input logic [5:0] le_b, input logic [5:0] te_b);
        data_in        = {col, b2g(te_b), b2g(le_b), row};
        data_in_strobe = 1'b1;
        @(negedge clk_out);
        data_in_strobe = 1'b0;
    endtask

    task automatic burst(input int n, input int push_limit);
        for (int i = 0; i < n; i++) begin
            logic [5:0] col, le_b, te_b;
            logic [8:0] row;
            col  = 6'(i + 1);
            row  = 9'(i * 17 + 3);
            le_b = 6'(i * 7);
            te_b = 6'(i * 13 + 5);
            data_in        = {col, b2g(te_b), b2g(le_b), row};
            data_in_strobe = 1'b1;
            if (i < push_limit) exp_q.push_back(hit_word(col, row, le_b, te_b));
            @(negedge clk_out);
        end
        data_in_strobe = 1'b0;
    endtask

    task automatic drain(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            @(negedge clk_out);
            budget++;
            if (dout_valid) begin
                logic [31:0] exp;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("drain_word", dout, exp);
                dout_ready = 1'b1;
                got++;
            end else begin
                dout_ready = 1'b0;
            end
        end
        if (got < n) check("drain_timeout", 32'(got), 32'(n));
        @(negedge clk_out);
        dout_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        data_in        = '0;
        data_in_strobe = 1'b0;
        dout_ready     = 1'b0;
`ifdef TOT_CUT_EN
        tot_min        = 6'd0;
`else
        tot_min        = 6'd63;
`endif
        repeat (3) @(negedge clk_out);
        reset = 1'b0;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // ToT basic with latency: Gray 000011 -> 2, Gray 000110 -> 4
        exp_q.push_back(hit_word(6'd5, 9'd100, g2b(6'b000011), g2b(6'b000110)));
        data_in        = {6'd5, 6'b000110, 6'b000011, 9'd100};
        data_in_strobe = 1'b1;
        @(negedge clk_out);
        data_in_strobe = 1'b0;
        @(negedge clk_out);
        check("lat_cycle2_valid", 32'(dout_valid), 32'd0);
        @(negedge clk_out);
        check("lat_cycle3_valid", 32'(dout_valid), 32'd1);
        check("basic_flag", 32'(dout[31]), 32'd0);
        check("basic_col", 32'(dout[30:25]), 32'd5);
        check("basic_row", 32'(dout[24:16]), 32'd100);
        check("basic_le", 32'(dout[15:10]), 32'd2);
        check("basic_tot", 32'(dout[9:4]), 32'd2);
        check("basic_word", dout, exp_q.pop_front());
        dout_ready = 1'b1;
        @(negedge clk_out);
        dout_ready = 1'b0;
        check("basic_empty", 32'(dout_valid), 32'd0);

        // ToT wrap: le 62, te 1 -> 3
        exp_q.push_back({1'b0, 6'd9, 9'd300, 6'd62, 6'd3, 4'd0});
        data_in        = {6'd9, 6'b000001, 6'b100001, 9'd300};
        data_in_strobe = 1'b1;
        @(negedge clk_out);
        data_in_strobe = 1'b0;
        drain(1);

        // Back-to-back throughput
        burst(4, 4);
        drain(4);
        check("tp_count", 32'(fifo_count), 32'd0);

        // Overflow and marker
        check("ovf_pre", 32'(overflow), 32'd0);
        burst(20, 16);
        repeat (3) @(negedge clk_out);
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_drop", 32'(drop_cnt), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain(1);
        @(negedge clk_out);
        exp_q.push_back(32'h8000_0004);
        check("mk_drop_clr", 32'(drop_cnt), 32'd0);
        check("mk_count", 32'(fifo_count), 32'd16);
        drain(16);
        check("mk_empty", 32'(fifo_count), 32'd0);

        // Simultaneous pop and hit at full
        reset = 1'b1;
        @(negedge clk_out);
        reset = 1'b0;
        exp_q.delete();
        burst(16, 16);
        repeat (3) @(negedge clk_out);
        check("sp_full", 32'(fifo_count), 32'd16);
        send_hit(6'd33, 9'd1, 6'd0, 6'd10);
        @(negedge clk_out);
        check("sp_head", dout, exp_q.pop_front());
        dout_ready = 1'b1;
        @(negedge clk_out);
        dout_ready = 1'b0;
        check("sp_count", 32'(fifo_count), 32'd15);
        check("sp_drop", 32'(drop_cnt), 32'd1);
        check("sp_ovf", 32'(overflow), 32'd1);
        exp_q.push_back(32'h8000_0001);
        @(negedge clk_out);
        check("sp_mk_drop", 32'(drop_cnt), 32'd0);
        drain(16);

        // Reset mid-stream with 7 words buffered
        for (int i = 0; i < 10; i++) begin
            data_in        = {6'(i), 6'd20, 6'd4, 9'(i)};
            data_in_strobe = 1'b1;
            if (i == 9) begin
                check("rm_count7", 32'(fifo_count), 32'd7);
                reset = 1'b1;
            end
            @(negedge clk_out);
        end
        reset          = 1'b0;
        data_in_strobe = 1'b0;
        check("rm_valid", 32'(dout_valid), 32'd0);
        check("rm_count", 32'(fifo_count), 32'd0);
        check("rm_drop", 32'(drop_cnt), 32'd0);
        check("rm_ovf", 32'(overflow), 32'd0);
        repeat (6) @(negedge clk_out);
        check("rm_no_stale_valid", 32'(dout_valid), 32'd0);
        check("rm_no_stale_count", 32'(fifo_count), 32'd0);

        // ToT cut: tot 3 and tot 4 with tot_min 4
        tot_min = 6'd4;
`ifdef TOT_CUT_EN
        exp_q.push_back(hit_word(6'd2, 9'd22, 6'd10, 6'd14));
`else
        exp_q.push_back(hit_word(6'd1, 9'd11, 6'd10, 6'd13));
        exp_q.push_back(hit_word(6'd2, 9'd22, 6'd10, 6'd14));
`endif
        send_hit(6'd1, 9'd11, 6'd10, 6'd13);
        send_hit(6'd2, 9'd22, 6'd10, 6'd14);
        drain(exp_q.size());
        repeat (3) @(negedge clk_out);
        check("cut_empty", 32'(dout_valid), 32'd0);
        check("cut_drop", 32'(drop_cnt), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_formatter.md
Name: hit_formatter

Overview:
- Sits directly downstream of the per-flavour readout deserializer, one instance per readout flavour (PMOS_NOSF, PMOS, COMP, HV).
- Consumes the 27-bit hit word plus its one-cycle strobe. Gray-decodes LE/TE, computes ToT, packs a 32-bit output word and buffers it in a synchronous FIFO with a valid/ready output port.
- On FIFO overflow it counts dropped hits, then inserts a marker word carrying the drop count once space returns.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, at least 4.
- DROP_W, 16, width of the dropped-hit counter.

Ports:
- clk_out  input  1  readout clock; all state on posedge.
- reset  input  1  synchronous, active-high.
- data_in  input  27  deserialized hit word {col[5:0], te[5:0], le[5:0], row[8:0]}; te/le are Gray-coded.
- data_in_strobe  input  1  data_in valid for exactly this cycle; no backpressure to upstream.
- tot_min  input  6  minimum accepted ToT; used only with TOT_CUT_EN.
- dout  output  32  FIFO head word.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer pops when dout_valid && dout_ready.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  DROP_W  drops not yet reported by a marker.
- overflow  output  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Interface: one clock (clk_out); reset is synchronous and active-high, port name reset.
- Reset values: dout_valid=0, fifo_count=0, drop_cnt=0, overflow=0, all pipeline valids 0. dout is don't-care while dout_valid=0.
- Stage 1, edge after the strobe: register col and row; convert le and te to binary (bin[5]=g[5], bin[i]=bin[i+1]^g[i]); s1_valid=strobe.
- Stage 2: tot=(te_bin-le_bin) mod 64, a 6-bit unsigned wrap. Hit word: [31]=0, [30:25]=col, [24:16]=row, [15:10]=le_bin, [9:4]=tot, [3:0]=0.
- Marker word: [31]=1, [30:16]=0, [15:0]=drop_cnt, zero-extended or truncated to 16 bits.
- Write arbitration, each cycle, with full defined as fifo_count==DEPTH before any same-cycle pop:
  - s2 hit valid and not full: write the hit.
  - s2 hit valid and full: drop the hit; drop_cnt increments, saturating at all-ones; overflow<=1.
  - no s2 hit, drop_cnt!=0, not full: write a marker; drop_cnt<=0 in the same cycle.
  - A hit always has priority over a marker. The marker precedes any hit arriving in a later cycle.
- A write and a pop in the same cycle leave fifo_count unchanged. A pop when empty is ignored.
- Latency: strobe high in cycle 0 gives the word written at the end of cycle 2. With the FIFO empty, dout_valid rises in cycle 3 with dout equal to that word.
- FIFO storage: show-ahead. dout = mem[rd_ptr]. Pointers are log2(DEPTH) bits and wrap naturally.
- Reset asserted mid-operation flushes the FIFO and both pipeline stages, with no partial output.
- Strobes in consecutive cycles are accepted; throughput is one hit per cycle.

Optional Feature:
- Macro: TOT_CUT_EN.
- Defined: a stage-2 hit with tot < tot_min is discarded. It is not written, not counted in drop_cnt, and does not set overflow. tot_min=0 passes everything.
- Undefined: tot_min is ignored and every hit is written or dropped by the FIFO rules only.

Decomposition:
- Package monopix_hit_pkg holds:
  - the t_data packed struct {col, te, le, row};
  - the output field position constants HIT_FLAG_BIT, COL_LSB, ROW_LSB, LE_LSB, TOT_LSB;
  - the marker flag constant.
- Sub-module hit_sync_fifo: parameterised DEPTH/width synchronous show-ahead FIFO exposing wr_en, rd_en, full, empty, count.
- Gray decode is a package function, not a separate module.

Test Plan:
- ToT basic: strobe data_in col=5, row=100, le Gray 000011 (bin 2), te Gray 000110 (bin 4) -> cycle 3: dout_valid=1, dout[30:25]=5, [24:16]=100, [15:10]=2, [9:4]=2, [31]=0.
- ToT wrap: le Gray 100001 (bin 62), te Gray 000001 (bin 1) -> tot=3.
- Overflow: dout_ready=0, DEPTH=16, send 20 strobes -> fifo_count=16, drop_cnt=4, overflow=1. Pop one word, send no strobe -> next write is marker 0x80000004 and drop_cnt returns to 0. The marker follows the 15 remaining hits.
- Simultaneous pop at full: fifo_count=16 with a pop and a strobe landing in stage 2 in the same cycle -> hit dropped, drop_cnt=1, fifo_count=15.
- Reset mid-stream: assert reset during back-to-back strobes with FIFO at 7 -> next cycle dout_valid=0, fifo_count=0, drop_cnt=0, overflow=0. No stale word appears afterwards.
- TOT_CUT_EN defined, tot_min=4: hits with tot 3 and tot 4 -> only the tot=4 word appears; drop_cnt stays 0.
